mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store initiator that drives the byte-enabled data memory port (WE, BE, A, WD in; RD out) on behalf of the pipeline's MEM stage.
- Accepts one load/store request per handshake and checks alignment.
- Generates the byte enables and lane-aligned write data.
- Extracts and sign/zero-extends read data, then returns a single-cycle response.
- The memory honours only single-byte or full-word enables, so a halfword store is split into two sequential byte writes.

Parameters:
- ADDR_W, 32, address width presented to memory.
- DATA_W, 32, data width; fixed at 32, kept for documentation only.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; a request transfers when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address; signed values allowed and passed through unchanged.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal-size request; valid with resp_valid.
- mem_WE  out  1  memory write enable.
- mem_BE  out  4  memory byte enable.
- mem_A  out  32  memory address, {addr[31:2],2'b00}.
- mem_WD  out  32  memory write data.
- mem_RD  in  32  memory read data; asynchronous, valid in the same cycle as mem_A.

Behaviour:
- Reset (rst_n=0, effective immediately):
  - State goes to IDLE.
  - All outputs are 0, including req_ready.
  - req_ready rises on the first clk edge after rst_n releases.
  - A reset during any write state drops mem_WE at once, so no further bytes are written.
  - A write that the memory has already sampled is not undone.
- mem_* outputs are registered, not decoded combinationally. Because the memory writes on the falling clock edge, WE/BE/WD must be stable and glitch-free through the whole cycle.
- FSM states: IDLE, WR0, WR1, RD, RESP.
- IDLE:
  - req_ready=1.
  - On transfer, latch addr, wdata, size, write and unsigned.
  - If the request is misaligned, go to RESP with error=1 and perform no memory access. Misaligned means: size 11; size 01 with addr[0]=1; or size 10 with addr[1:0]≠0.
  - Otherwise: a store goes to WR0, a load goes to RD.
- WR0, one cycle, mem_WE=1:
  - Byte store: BE = 1<<addr[1:0]; WD holds the byte replicated in all four lanes. Next state RESP.
  - Word store: BE=1111, WD=wdata. Next state RESP.
  - Halfword store: BE = 1<<addr[1:0], WD lane = wdata[7:0]. Next state WR1.
- WR1, halfword store only, one cycle, mem_WE=1:
  - BE = 1<<(addr[1:0]+1), WD lane = wdata[15:8]. Next state RESP.
- RD, one cycle, mem_WE=0, BE=0:
  - mem_A is driven; mem_RD is captured at the rising edge ending the cycle.
  - The selected byte or halfword (by addr[1:0]) is extended per req_unsigned.
  - Word loads are passed through.
  - Next state RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; mem_WE=0; req_ready=0.
  - Next state IDLE.
  - There is no response backpressure.
- Latency, counted from the accept edge to resp_valid high:
  - byte/word store: 2 cycles.
  - halfword store: 3 cycles.
  - load: 2 cycles.
  - error: 1 cycle.
- Throughput: requests offered while not in IDLE are held off by req_ready=0. Back-to-back issue is possible when req_valid is asserted in the IDLE cycle after RESP.
- resp_rdata and resp_error hold their values until the next response; both are cleared on reset.

Test Plan:
1. sw addr 0x10, data 0xDEADBEEF -> exactly one cycle with mem_WE=1, BE=1111, mem_A=0x10, WD=0xDEADBEEF; resp_valid 2 cycles after accept, resp_error=0, resp_rdata=0.
2. Memory zeroed; sh addr 0x22, data 0x0000A55A -> WR0: BE=0100 with 0x5A in lane 2; WR1: BE=1000 with 0xA5 in lane 3; resp after 3 cycles. A following lw 0x20 returns 0xA55A0000.
3. After test 2: lb 0x23 -> 0xFFFFFFA5; lbu 0x23 -> 0x000000A5; lh 0x22 -> 0xFFFFA55A; lhu 0x22 -> 0x0000A55A.
4. lw 0x21, lh 0x13, and size=11 at 0x0 -> each gives resp_error=1, resp_rdata=0, resp_valid 1 cycle after accept, and mem_WE never asserted.
5. sh in progress, rst_n driven low mid-WR1 before the falling edge -> mem_WE drops immediately, only the low byte is written, outputs are 0; after release req_ready=1 and a new lw works.
6. sw 0xFFFFFFFC data 0x12345678, then lw 0xFFFFFFFC issued back-to-back -> mem_A=0xFFFFFFFC for both, load returns 0x12345678, and req_ready is low throughout each operation.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator driving a byte-enabled data memory port on behalf of MEM.
// Latency: error 1, load/byte/word store 2, halfword store 3 cycles; req_ready low while busy.
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_error,
   output logic              mem_WE,
   output logic [3:0]        mem_BE,
   output logic [ADDR_W-1:0] mem_A,
   output logic [DATA_W-1:0] mem_WD,
   input  logic [DATA_W-1:0] mem_RD
);

   typedef enum logic [2:0] {IDLE, WR0, WR1, RD, RESP} state_t;

   state_t state, next_state;

   logic [1:0] size_q;
   logic       uns_q;
   logic [1:0] off_q;
   logic [7:0] hb_q;

   logic accept;
   logic misaligned;

   logic              req_ready_d;
   logic              resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_d;
   logic              resp_error_d;
   logic              mem_we_d;
   logic [3:0]        mem_be_d;
   logic [ADDR_W-1:0] mem_a_d;
   logic [DATA_W-1:0] mem_wd_d;

   logic [DATA_W-1:0] lane;
   logic [DATA_W-1:0] load_val;

   assign accept     = req_valid && req_ready;
   assign misaligned = (req_size == 2'b11) ||
                       (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (misaligned)     next_state = RESP;
               else if (req_write) next_state = WR0;
               else                next_state = RD;
            end
         end
         WR0:     next_state = (size_q == 2'b01) ? WR1 : RESP;
         WR1:     next_state = RESP;
         RD:      next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Load extraction: the selected lane is shifted down to bit 0 before extension
   always_comb begin
      lane = mem_RD >> {off_q, 3'b000};
      case (size_q)
         2'b00:   load_val = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         2'b01:   load_val = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: load_val = mem_RD;
      endcase
   end

   // Output decode: values computed for the state being entered, then registered
   always_comb begin
      req_ready_d  = (next_state == IDLE);
      resp_valid_d = (next_state == RESP);
      resp_rdata_d = resp_rdata;
      resp_error_d = resp_error;
      mem_we_d     = (next_state == WR0) || (next_state == WR1);
      mem_be_d     = 4'b0000;
      mem_a_d      = mem_A;
      mem_wd_d     = mem_WD;

      if (state == IDLE && accept && !misaligned) begin
         mem_a_d = {req_addr[ADDR_W-1:2], 2'b00};
      end

      if (next_state == WR0) begin
         if (req_size == 2'b10) begin
            mem_be_d = 4'b1111;
            mem_wd_d = req_wdata;
         end else begin
            mem_be_d = 4'b0001 << req_addr[1:0];
            mem_wd_d = {4{req_wdata[7:0]}};
         end
      end else if (next_state == WR1) begin
         mem_be_d = 4'b0001 << (off_q + 2'd1);
         mem_wd_d = {4{hb_q}};
      end

      if (next_state == RESP) begin
         resp_rdata_d = (state == RD) ? load_val : '0;
         resp_error_d = (state == IDLE);
      end
   end

   // Registered outputs keep WE/BE/WD glitch-free for the falling-edge memory write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_error <= 1'b0;
         mem_WE     <= 1'b0;
         mem_BE     <= 4'b0000;
         mem_A      <= '0;
         mem_WD     <= '0;
      end else begin
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         resp_rdata <= resp_rdata_d;
         resp_error <= resp_error_d;
         mem_WE     <= mem_we_d;
         mem_BE     <= mem_be_d;
         mem_A      <= mem_a_d;
         mem_WD     <= mem_wd_d;
      end
   end

   // Request fields needed after the accept cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         size_q <= 2'b00;
         uns_q  <= 1'b0;
         off_q  <= 2'b00;
         hb_q   <= 8'h00;
      end else if (state == IDLE && accept) begin
         size_q <= req_size;
         uns_q  <= req_unsigned;
         off_q  <= req_addr[1:0];
         hb_q   <= req_wdata[15:8];
      end
   end

endmodule
